// File: rtl/scan_pkg.sv
// Shared definitions for the 2x4 decoder scan sequencer.
//   scan_state_e : sequencer FSM states. BLANK is only reachable when the
//                  design is built with SCAN_BLANK_EN defined.
//   CH_W, NUM_CH : channel index width and channel count.
package scan_pkg;

  localparam int CH_W   = 2;
  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    BLANK = 2'd2
  } scan_state_e;

endpackage

// File: rtl/scan_next_ch.sv
// Combinational next-channel search for the scan sequencer.
// Searches upward from cur+1, wrapping 3->0, and finally considers cur itself,
// so the current channel is picked again only when it is the sole enabled one.
// Ports:
//   cur     : current channel index
//   ch_mask : bit i = channel i enabled
//   next    : next enabled channel index (cur when none found)
//   found   : at least one channel enabled
//   wrapped : next <= cur, i.e. the search went past channel 3 or stayed put
module scan_next_ch
  import scan_pkg::*;
(
  input  logic [CH_W-1:0]   cur,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [CH_W-1:0]   next,
  output logic              found,
  output logic              wrapped
);

  logic [CH_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest enabled channel
  // overwrites any farther candidate.
  always_comb begin
    next  = cur;
    found = 1'b0;
    idx   = cur;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = cur + CH_W'(i);
      if (ch_mask[idx]) begin
        next  = idx;
        found = 1'b1;
      end
    end
  end

  assign wrapped = found && (next <= cur);

endmodule

// File: rtl/scan_sequencer_2x4.sv
// Registered 2-bit channel sequencer driving the a/b inputs of a 2x4 decoder.
// Scans the enabled channels of ch_mask, holding each for dwell+1 cycles,
// either once (oneshot=1) or continuously until stop.
// Optional build macro: SCAN_BLANK_EN inserts one BLANK cycle (valid=0,
// busy=1, old channel held) between consecutive channels.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin scan (IDLE only); stop aborts (non-IDLE, wins over start)
//   oneshot    : single pass when 1, captured on accepted start
//   dwell      : hold time minus one, sampled on channel entry
//   ch_mask    : channel enables, sampled live at each channel selection
//   a, b       : channel index MSB/LSB (hold last channel in IDLE)
//   valid      : {a,b} is an active selection
//   busy       : sequencer not IDLE
//   ch_tick    : pulse in the last dwell cycle of each channel
//   done       : pulse after a one-shot pass completes
//   dbg_state  : current FSM state
//
// Handshake: start and stop are level-sampled request strobes on every rising
// edge; there is no ready. valid qualifies {a,b} in the same cycle, and every
// output is a register updated only on the rising edge.
module scan_sequencer_2x4
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               oneshot,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NUM_CH-1:0]  ch_mask,
  output logic               a,
  output logic               b,
  output logic               valid,
  output logic               busy,
  output logic               ch_tick,
  output logic               done,
  output scan_state_e        dbg_state
);

  scan_state_e        state, state_n;
  logic [CH_W-1:0]    ch, ch_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic               os_q, os_n;
  logic               valid_q, busy_q, tick_q, done_q;
  logic               valid_n, busy_n, tick_n, done_n;

  logic [CH_W-1:0]    cur_sel;
  logic [CH_W-1:0]    nx_ch;
  logic               nx_found;
  logic               nx_wrapped;

  // From IDLE the search starts "after channel 3", which yields the lowest
  // enabled channel.
  assign cur_sel = (state == IDLE) ? CH_W'(NUM_CH - 1) : ch;

  scan_next_ch u_next (
    .cur     (cur_sel),
    .ch_mask (ch_mask),
    .next    (nx_ch),
    .found   (nx_found),
    .wrapped (nx_wrapped)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ch      <= '0;
      cnt     <= '0;
      os_q    <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      ch      <= ch_n;
      cnt     <= cnt_n;
      os_q    <= os_n;
      valid_q <= valid_n;
      busy_q  <= busy_n;
      tick_q  <= tick_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    ch_n    = ch;
    cnt_n   = cnt;
    os_n    = os_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop && nx_found) begin
          state_n = DWELL;
          ch_n    = nx_ch;
          cnt_n   = dwell;
          os_n    = oneshot;
        end
      end
      DWELL: begin
        if (stop) begin
          state_n = IDLE;
        end else if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (!nx_found) begin
          state_n = IDLE;
        end else if (os_q && nx_wrapped) begin
          // Last enabled channel of a one-shot pass: exit without blanking.
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
`ifdef SCAN_BLANK_EN
          state_n = BLANK;
`else
          ch_n  = nx_ch;
          cnt_n = dwell;
`endif
        end
      end
`ifdef SCAN_BLANK_EN
      BLANK: begin
        // Channel choice is re-evaluated here against the live mask.
        if (stop || !nx_found) begin
          state_n = IDLE;
        end else if (os_q && nx_wrapped) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          state_n = DWELL;
          ch_n    = nx_ch;
          cnt_n   = dwell;
        end
      end
`endif
      default: state_n = IDLE;
    endcase

    // Outputs are computed from the next state so they can be registered
    // without adding a cycle of latency.
    valid_n = (state_n == DWELL);
    busy_n  = (state_n != IDLE);
    tick_n  = (state_n == DWELL) && (cnt_n == '0);
  end

  assign a         = ch[1];
  assign b         = ch[0];
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign ch_tick   = tick_q;
  assign done      = done_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_scan_sequencer_2x4.sv
// Directed bench for scan_sequencer_2x4. Each scan pushes its hand-computed
// per-cycle output words {valid,busy,done,ch_tick,a,b} into exp_q; the
// monitor pops and compares one word for every cycle with busy or done high.
module tb_scan_sequencer_2x4;
  import scan_pkg::*;

  localparam int W = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        oneshot = 1'b0;
  logic [7:0]  dwell = '0;
  logic [3:0]  ch_mask = '0;
  logic        a, b, valid, busy, ch_tick, done;
  scan_state_e dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  scan_sequencer_2x4 #(.DWELL_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .oneshot   (oneshot),
    .dwell     (dwell),
    .ch_mask   (ch_mask),
    .a         (a),
    .b         (b),
    .valid     (valid),
    .busy      (busy),
    .ch_tick   (ch_tick),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Expected-word helpers
  function automatic void push_act(input logic t, input logic [1:0] c);
    exp_q.push_back({1'b1, 1'b1, 1'b0, t, c});
  endfunction

  function automatic void push_done(input logic [1:0] c);
    exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b0, c});
  endfunction

  function automatic void push_blank(input logic [1:0] c);
    exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, c});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input logic os, input logic [7:0] dw, input logic [3:0] m);
    start   = 1'b1;
    oneshot = os;
    dwell   = dw;
    ch_mask = m;
    wait_cycles(1);
    start   = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    wait_cycles(1);
    stop = 1'b0;
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_valid"}, 32'(valid), 32'd0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] obs;
    logic [W-1:0] e;
    if (busy === 1'b1 || done === 1'b1) begin
      obs = {valid, busy, done, ch_tick, a, b};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mon_unexpected: got %b, expected no activity", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++;
          $display("FAIL mon_word: got %b, expected %b (v,busy,done,tick,a,b)", obs, e);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    errors++;
    checks++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    wait_cycles(3);
    rst = 1'b0;
    check("rst_ab", 32'({a, b}), 32'd0);
    check("rst_tick", 32'(ch_tick), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check_idle("rst");

`ifdef SCAN_BLANK_EN
    // Two channels with a blank gap on every change, including the wrap.
    push_act(1'b0, 2'd0); push_act(1'b1, 2'd0); push_blank(2'd0);
    push_act(1'b0, 2'd1); push_act(1'b1, 2'd1); push_blank(2'd1);
    push_act(1'b0, 2'd0); push_act(1'b1, 2'd0);
    start_scan(1'b0, 8'd1, 4'b0011);
    wait_cycles(7);
    pulse_stop();
    check_idle("blank_stop");
`else
    // Basic continuous scan over all channels, then stop.
    for (int k = 0; k < 5; k++) begin
      push_act(1'b0, 2'(k));
      push_act(1'b1, 2'(k));
    end
    start_scan(1'b0, 8'd1, 4'b1111);
    wait_cycles(9);
    pulse_stop();
    check_idle("cont_stop");
    check("cont_stop_ab", 32'({a, b}), 32'd0);
    check("cont_stop_tick", 32'(ch_tick), 32'd0);

    // One-shot skipping disabled channels.
    push_act(1'b1, 2'd1);
    push_act(1'b1, 2'd3);
    push_done(2'd3);
    start_scan(1'b1, 8'd0, 4'b1010);
    wait_cycles(4);
    check_idle("os_skip");
    check("os_skip_ab", 32'({a, b}), 32'd3);

    // Single channel, continuous.
    for (int k = 0; k < 2; k++) begin
      push_act(1'b0, 2'd2); push_act(1'b0, 2'd2);
      push_act(1'b0, 2'd2); push_act(1'b1, 2'd2);
    end
    start_scan(1'b0, 8'd3, 4'b0100);
    wait_cycles(7);
    pulse_stop();
    check_idle("single_cont");

    // Single channel, one-shot.
    push_act(1'b0, 2'd2); push_act(1'b0, 2'd2);
    push_act(1'b0, 2'd2); push_act(1'b1, 2'd2);
    push_done(2'd2);
    start_scan(1'b1, 8'd3, 4'b0100);
    wait_cycles(6);
    check_idle("single_os");

    // Start with no enabled channel is ignored.
    start_scan(1'b0, 8'd1, 4'b0000);
    check_idle("mask0_start");
    wait_cycles(2);
    check_idle("mask0_later");

    // Start and stop together: stop wins.
    stop = 1'b1;
    start_scan(1'b0, 8'd1, 4'b1111);
    stop = 1'b0;
    check_idle("start_stop");

    // Start while busy does not disturb the pass.
    push_act(1'b0, 2'd0); push_act(1'b1, 2'd0);
    push_act(1'b0, 2'd1); push_act(1'b1, 2'd1);
    push_done(2'd1);
    start_scan(1'b1, 8'd1, 4'b0011);
    start   = 1'b1;
    oneshot = 1'b0;
    wait_cycles(1);
    start   = 1'b0;
    wait_cycles(5);
    check_idle("start_busy");

    // Mask cleared mid-dwell: IDLE at dwell end, no done.
    push_act(1'b0, 2'd0); push_act(1'b0, 2'd0);
    push_act(1'b0, 2'd0); push_act(1'b1, 2'd0);
    start_scan(1'b0, 8'd3, 4'b1111);
    ch_mask = 4'b0000;
    wait_cycles(5);
    check_idle("mask_clear");
    check("mask_clear_done", 32'(done), 32'd0);

    // Maximum dwell: 256 cycles on one channel.
    for (int k = 0; k < 255; k++) push_act(1'b0, 2'd0);
    push_act(1'b1, 2'd0);
    push_done(2'd0);
    start_scan(1'b1, 8'd255, 4'b0001);
    wait_cycles(260);
    check_idle("dwell_max");

    // Reset during channel 2 dwell.
    for (int c = 0; c < 2; c++) begin
      push_act(1'b0, 2'(c)); push_act(1'b0, 2'(c));
      push_act(1'b0, 2'(c)); push_act(1'b1, 2'(c));
    end
    push_act(1'b0, 2'd2);
    start_scan(1'b0, 8'd3, 4'b1111);
    wait_cycles(8);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    check_idle("mid_rst");
    check("mid_rst_ab", 32'({a, b}), 32'd0);
    check("mid_rst_tick", 32'(ch_tick), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));

    // Restart after reset begins at the lowest enabled channel.
    push_act(1'b1, 2'd1);
    push_act(1'b1, 2'd2);
    push_done(2'd2);
    start_scan(1'b1, 8'd0, 4'b0110);
    wait_cycles(4);
    check_idle("post_rst");
`endif

    wait_cycles(5);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scan_sequencer_2x4.md
Name: scan_sequencer_2x4

Overview:
- Registered 2-bit channel sequencer that sits directly upstream of the team's 2x4 decoder.
- Drives the decoder's a (MSB) and b (LSB) inputs to scan four channels, e.g. display digit strobes or bus-select lines.
- Each channel is held for a programmable dwell time.
- Masked-off channels are skipped.
- Supports continuous and one-shot scanning with start/stop control.

Parameters:
- DWELL_W, 8, width of the dwell count input and internal dwell counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a scan; honoured only in IDLE.
- stop  in  1  abort request; honoured in any non-IDLE state.
- oneshot  in  1  1 = single pass over enabled channels; 0 = loop until stop. Sampled on an accepted start.
- dwell  in  DWELL_W  channel hold time minus 1. Sampled each time a channel is entered.
- ch_mask  in  4  bit i = channel i enabled. Sampled live at each channel selection.
- a  out  1  channel index MSB, to decoder a.
- b  out  1  channel index LSB, to decoder b.
- valid  out  1  {a,b} is an active channel selection.
- busy  out  1  sequencer not IDLE.
- ch_tick  out  1  one-cycle pulse in the last cycle of each channel's dwell.
- done  out  1  one-cycle pulse when a one-shot pass completes.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst); all outputs are registered.
- Reset: state IDLE. a=0, b=0, valid=0, busy=0, ch_tick=0, done=0, dwell counter=0. A reset mid-scan produces these values on the next edge; no done pulse.
- States: IDLE, DWELL, and BLANK (BLANK exists only with the optional feature).
- IDLE:
  - start=1, stop=0, ch_mask!=0: go to DWELL on the lowest-index enabled channel. Load counter from dwell. Capture oneshot.
  - Latency: start sampled at edge N gives valid=1, busy=1 and the new {a,b} after edge N.
  - start with ch_mask==0: ignored, stays IDLE.
  - stop in IDLE: no effect.
- DWELL:
  - Counter decrements each cycle, so the channel is held for dwell+1 cycles. dwell=0 gives 1 cycle; dwell=2^DWELL_W-1 gives 2^DWELL_W cycles.
  - ch_tick=1 during the cycle with counter==0.
  - At counter==0, next channel = first enabled index after the current one, searching upward and wrapping 3->0. The current channel is eligible again only if it is the sole enabled channel.
  - One-shot: if no enabled channel exists at a higher index than the current one, go to IDLE. done=1 for one cycle while valid=0 and busy=0.
  - Continuous: wraps indefinitely.
  - ch_mask==0 at an advance point: go to IDLE with no done pulse.
- Stop (any non-IDLE state): next edge IDLE, valid=0, busy=0, no done, no ch_tick beyond the current cycle. Start and stop in the same cycle: stop wins. Start while busy: ignored.
- In IDLE, {a,b} holds the last driven channel and valid=0. Downstream gates decoder outputs with valid.
- Counter arithmetic is unsigned DWELL_W bits with no wrap below 0; reload occurs on channel entry.

Optional Feature:
- Macro: SCAN_BLANK_EN.
- Defined:
  - Every channel-to-channel transition inserts one BLANK cycle: valid=0, busy=1, {a,b} holds the old channel.
  - The next channel's dwell starts after BLANK.
  - stop during BLANK goes to IDLE.
  - The final one-shot exit goes directly to IDLE without a BLANK.
  - Purpose: anti-ghosting gap between strobes.
- Not defined: no BLANK state. Transitions are back-to-back with valid continuously 1 across channel changes.

Decomposition:
- Package scan_pkg holds:
  - state enum (IDLE, DWELL, BLANK).
  - constants CH_W=2, NUM_CH=4.
- Sub-module scan_next_ch (combinational):
  - Inputs: current index and ch_mask. Outputs: next enabled index with wrap, a found flag, and a wrapped flag (next index <= current).
  - The wrapped flag drives the one-shot exit.

Test Plan:
- Basic continuous: ch_mask=4'b1111, dwell=1, oneshot=0, start pulse. Expect {a,b} = 00,01,10,11,00,... each held 2 cycles, valid=1 throughout, ch_tick every 2nd cycle, stop then gives IDLE next cycle.
- One-shot with skip: ch_mask=4'b1010, dwell=0, oneshot=1. Expect {a,b}=01 for 1 cycle, then 11 for 1 cycle, then done=1 pulse, busy=0.
- Single channel: ch_mask=4'b0100, dwell=3, continuous. Expect {a,b}=10 steady, ch_tick every 4 cycles. With oneshot=1, done arrives after 4 cycles.
- Edge controls:
  - start with ch_mask=0: stays IDLE.
  - start+stop in the same cycle: stays IDLE.
  - start while busy: sequence unaffected.
  - ch_mask cleared mid-dwell: IDLE at dwell end, no done.
- Reset mid-run during a channel-2 dwell: next cycle all outputs 0, state IDLE. A following start begins from the lowest enabled channel.
- SCAN_BLANK_EN: ch_mask=4'b0011, dwell=1, continuous. Expect valid pattern 1,1,0,1,1,0. {a,b} holds the old value in the blank cycle; BLANK also occurs on the 01->00 wrap.
